// File: rtl/ras_ckpt_ctrl_if.sv
// ras_ckpt_ctrl_if
//   Groups the prediction, resolution and RAS command signals of the RAS
//   speculation controller into one bundle.
//   master : environment side (fetch/EX drive predictions and resolutions,
//            observe RAS commands and stall/occupancy status)
//   slave  : controller side (ras_ckpt_ctrl)
//   Parameters: PTR_W (RAS pointer width), CNT_W (checkpoint count width).
interface ras_ckpt_ctrl_if #(
    parameter int PTR_W = 5,
    parameter int CNT_W = 4
);
    logic             BPU__Stall;
    logic             Pred_Valid;
    logic             Pred_Is_Call;
    logic             Pred_Is_Ret;
    logic [31:0]      Pred_Next_PC;
    logic             Res_Valid;
    logic             Res_Mispredict;
    logic             Flush;
    logic             RAS_Push;
    logic [31:0]      RAS_Push_Addr;
    logic             RAS_Pop;
    logic             RAS_Restore;
    logic [PTR_W-1:0] RAS_Restore_TOS;
    logic             Ckpt_Full;
    logic             Ctrl_Stall;
    logic [CNT_W-1:0] Ckpt_Count;

    modport master (
        output BPU__Stall, Pred_Valid, Pred_Is_Call, Pred_Is_Ret, Pred_Next_PC,
        output Res_Valid, Res_Mispredict, Flush,
        input  RAS_Push, RAS_Push_Addr, RAS_Pop, RAS_Restore, RAS_Restore_TOS,
        input  Ckpt_Full, Ctrl_Stall, Ckpt_Count
    );

    modport slave (
        input  BPU__Stall, Pred_Valid, Pred_Is_Call, Pred_Is_Ret, Pred_Next_PC,
        input  Res_Valid, Res_Mispredict, Flush,
        output RAS_Push, RAS_Push_Addr, RAS_Pop, RAS_Restore, RAS_Restore_TOS,
        output Ckpt_Full, Ctrl_Stall, Ckpt_Count
    );
endinterface

// File: rtl/ras_ckpt_ctrl.sv
// ras_ckpt_ctrl
//   Speculation controller for the BPU return address stack. Accepted fetch
//   CALL/RET predictions become registered RAS push/pop commands one cycle
//   later; the pre-update speculative TOS of every in-flight CALL/RET is kept
//   in a checkpoint FIFO. An EX mispredict on the oldest entry restores the
//   RAS TOS from its checkpoint (one-cycle RAS_Restore pulse) and then holds
//   fetch for two settle cycles so the RAS outputs are valid on resume.
// Ports
//   CLK, RST : clock (rising edge), synchronous active-high reset
//   bus      : ras_ckpt_ctrl_if.slave (prediction/resolution in, RAS commands,
//              Ckpt_Full, Ctrl_Stall, Ckpt_Count out)
// Configuration
//   RAS_UNDERFLOW_GUARD_EN : when defined, a shadow RAS occupancy (0..2**PTR_W)
//   is tracked and checkpointed; a RET accepted at occupancy 0 enqueues a
//   checkpoint but neither pops nor moves the speculative TOS.
module ras_ckpt_ctrl #(
    parameter int PTR_W = 5,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input logic            CLK,
    input logic            RST,
    ras_ckpt_ctrl_if.slave bus
);
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPAIR = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           state;
    logic             settle_cnt;
    logic [PTR_W-1:0] spec_tos;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CNT_W-1:0] ckpt_cnt;
    logic [PTR_W-1:0] q_tos [DEPTH];

    logic             push_p1;
    logic             pop_p1;
    logic [31:0]      push_addr_p1;
    logic             restore_p1;
    logic [PTR_W-1:0] restore_tos_p1;
    logic             stall_p1;

    logic             q_empty;
    logic             q_full;
    logic             mispred;
    logic             repair_go;
    logic             resolve_ok;
    logic             accept;
    logic             ret_ok;
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    wr_base;

    assign q_empty    = (ckpt_cnt == '0);
    assign q_full     = (ckpt_cnt == FULL_CNT);
    assign mispred    = bus.Res_Valid & bus.Res_Mispredict;
    // A mispredict blocks same-cycle predictions even when it finds nothing to repair.
    assign repair_go  = mispred & ~q_empty & (state == IDLE);
    assign resolve_ok = bus.Res_Valid & ~bus.Res_Mispredict & ~q_empty;
    assign accept     = bus.Pred_Valid & ~bus.BPU__Stall & ~q_full &
                        (state == IDLE) & ~mispred;
    assign do_push    = accept & bus.Pred_Is_Call;
    assign do_pop     = accept & ~bus.Pred_Is_Call & bus.Pred_Is_Ret & ret_ok;
    // A flush empties the FIFO this cycle, so a same-cycle accept lands in slot 0.
    assign wr_base    = bus.Flush ? '0 : wr_ptr;

`ifdef RAS_UNDERFLOW_GUARD_EN
    localparam logic [PTR_W:0] OCC_MAX = {1'b1, {PTR_W{1'b0}}};
    logic [PTR_W:0] occ;
    logic [PTR_W:0] q_occ [DEPTH];

    assign ret_ok = (occ != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            occ <= '0;
        end else if (repair_go) begin
            occ <= q_occ[rd_ptr];
        end else if (do_push) begin
            if (occ != OCC_MAX) occ <= occ + 1'b1;
        end else if (do_pop) begin
            occ <= occ - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) q_occ[wr_base] <= occ;
    end
`else
    assign ret_ok = 1'b1;
`endif

    // Checkpoint storage holds data only; validity is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (accept) q_tos[wr_base] <= spec_tos;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            spec_tos <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            ckpt_cnt <= '0;
        end else begin
            if (repair_go)    spec_tos <= q_tos[rd_ptr];
            else if (do_push) spec_tos <= spec_tos + 1'b1;
            else if (do_pop)  spec_tos <= spec_tos - 1'b1;

            // Mispredict outranks flush; both discard every in-flight entry.
            if (repair_go) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                ckpt_cnt <= '0;
            end else if (bus.Flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= accept ? AW'(1) : '0;
                ckpt_cnt <= accept ? CNT_W'(1) : '0;
            end else begin
                if (resolve_ok) rd_ptr <= rd_ptr + 1'b1;
                if (accept)     wr_ptr <= wr_ptr + 1'b1;
                ckpt_cnt <= ckpt_cnt + CNT_W'(accept) - CNT_W'(resolve_ok);
            end
        end
    end

    // ---- p1: registered RAS commands, one cycle after acceptance ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            push_p1      <= 1'b0;
            pop_p1       <= 1'b0;
            push_addr_p1 <= '0;
        end else begin
            push_p1 <= do_push;
            pop_p1  <= do_pop;
            if (do_push) push_addr_p1 <= bus.Pred_Next_PC;
        end
    end

    // Repair sequencer: REPAIR (restore pulse) then two SETTLE cycles, stall throughout.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            settle_cnt     <= 1'b0;
            restore_p1     <= 1'b0;
            restore_tos_p1 <= '0;
            stall_p1       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (repair_go) begin
                        state          <= REPAIR;
                        restore_p1     <= 1'b1;
                        restore_tos_p1 <= q_tos[rd_ptr];
                        stall_p1       <= 1'b1;
                    end
                end
                REPAIR: begin
                    state      <= SETTLE;
                    restore_p1 <= 1'b0;
                    settle_cnt <= 1'b0;
                end
                SETTLE: begin
                    if (settle_cnt) begin
                        state    <= IDLE;
                        stall_p1 <= 1'b0;
                    end else begin
                        settle_cnt <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    restore_p1 <= 1'b0;
                    stall_p1   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RAS_Push        = push_p1;
    assign bus.RAS_Push_Addr   = push_addr_p1;
    assign bus.RAS_Pop         = pop_p1;
    assign bus.RAS_Restore     = restore_p1;
    assign bus.RAS_Restore_TOS = restore_tos_p1;
    assign bus.Ckpt_Full       = q_full;
    assign bus.Ctrl_Stall      = stall_p1;
    assign bus.Ckpt_Count      = ckpt_cnt;
endmodule

// File: tb/tb_ras_ckpt_ctrl.sv
// tb_ras_ckpt_ctrl
//   Self-checking bench for ras_ckpt_ctrl. RAS push/pop commands are checked
//   against a scoreboard queue filled when an accepted prediction is driven;
//   counts, stall and restore behaviour are checked inline in each test task.
module tb_ras_ckpt_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic        push;
        logic [31:0] addr;
    } exp_t;
    exp_t exp_q[$];

    ras_ckpt_ctrl_if #(.PTR_W(5), .CNT_W(4)) bus ();

    ras_ckpt_ctrl #(.PTR_W(5), .DEPTH(8), .CNT_W(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

`ifdef RAS_UNDERFLOW_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    // Scoreboard consumer: every RAS command must match the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (bus.RAS_Push || bus.RAS_Pop || bus.RAS_Restore) begin
            if (bus.RAS_Push || bus.RAS_Pop) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cmd got push=%0d pop=%0d required none", bus.RAS_Push, bus.RAS_Pop);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.RAS_Push !== e.push || bus.RAS_Pop !== !e.push ||
                        (e.push && bus.RAS_Push_Addr !== e.addr)) begin
                        errors++;
                        $display("FAIL ras_cmd got push=%0d pop=%0d addr=%h required push=%0d addr=%h",
                                 bus.RAS_Push, bus.RAS_Pop, bus.RAS_Push_Addr, e.push, e.addr);
                    end
                end
            end
            checks++;
            if ((32'(bus.RAS_Push) + 32'(bus.RAS_Pop) + 32'(bus.RAS_Restore)) > 1) begin
                errors++;
                $display("FAIL cmd_exclusive got push=%0d pop=%0d restore=%0d required at most one",
                         bus.RAS_Push, bus.RAS_Pop, bus.RAS_Restore);
            end
        end
    end

    task automatic step(input logic pv, input logic call, input logic ret, input logic [31:0] pc,
                        input logic rv, input logic rm, input logic fl, input logic st,
                        input logic exp_cmd);
        exp_t e;
        bus.Pred_Valid     = pv;
        bus.Pred_Is_Call   = call;
        bus.Pred_Is_Ret    = ret;
        bus.Pred_Next_PC   = pc;
        bus.Res_Valid      = rv;
        bus.Res_Mispredict = rm;
        bus.Flush          = fl;
        bus.BPU__Stall     = st;
        if (exp_cmd) begin
            e.push = call;
            e.addr = pc;
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1;
        bus.Pred_Valid     = 1'b0;
        bus.Pred_Is_Call   = 1'b0;
        bus.Pred_Is_Ret    = 1'b0;
        bus.Pred_Next_PC   = '0;
        bus.Res_Valid      = 1'b0;
        bus.Res_Mispredict = 1'b0;
        bus.Flush          = 1'b0;
        bus.BPU__Stall     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle(2);
        checks++;
        if (bus.RAS_Push !== 1'b0 || bus.RAS_Pop !== 1'b0 || bus.RAS_Restore !== 1'b0 ||
            bus.RAS_Push_Addr !== 32'h0 || bus.RAS_Restore_TOS !== 5'd0 || bus.Ckpt_Full !== 1'b0 ||
            bus.Ctrl_Stall !== 1'b0 || bus.Ckpt_Count !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs got push=%0d pop=%0d rst=%0d addr=%h tos=%0d full=%0d stall=%0d cnt=%0d required all 0",
                     bus.RAS_Push, bus.RAS_Pop, bus.RAS_Restore, bus.RAS_Push_Addr, bus.RAS_Restore_TOS,
                     bus.Ckpt_Full, bus.Ctrl_Stall, bus.Ckpt_Count);
        end
        RST = 1'b0;
    endtask

    task automatic test_call();
        do_reset();
        step(1, 1, 0, 32'h100, 0, 0, 0, 0, 1);
        checks++;
        if (bus.RAS_Push !== 1'b1 || bus.RAS_Push_Addr !== 32'h100) begin
            errors++;
            $display("FAIL call_push got push=%0d addr=%h required 1 00000100", bus.RAS_Push, bus.RAS_Push_Addr);
        end
        checks++;
        if (bus.Ckpt_Count !== 4'd1) begin
            errors++;
            $display("FAIL call_count got %0d required 1", bus.Ckpt_Count);
        end
        // Resolve it, then checkpoint a second CALL: its checkpoint exposes Spec_TOS=1.
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 32'h104, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0, 0, 0);
        checks++;
        if (bus.RAS_Restore !== 1'b1 || bus.RAS_Restore_TOS !== 5'd1) begin
            errors++;
            $display("FAIL call_spec_tos got restore=%0d tos=%0d required 1 1", bus.RAS_Restore, bus.RAS_Restore_TOS);
        end
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL call_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_repair();
        int stall_cycles;
        do_reset();
        step(1, 1, 0, 32'h200, 0, 0, 0, 0, 1);
        step(1, 1, 0, 32'h204, 0, 0, 0, 0, 1);
        step(1, 0, 1, 32'h0,   0, 0, 0, 0, 1);
        checks++;
        if (bus.Ckpt_Count !== 4'd3) begin
            errors++;
            $display("FAIL repair_pre_count got %0d required 3", bus.Ckpt_Count);
        end
        step(0, 0, 0, 0, 1, 1, 0, 0, 0);
        checks++;
        if (bus.RAS_Restore !== 1'b1 || bus.RAS_Restore_TOS !== 5'd0 || bus.Ckpt_Count !== 4'd0) begin
            errors++;
            $display("FAIL repair_restore got restore=%0d tos=%0d cnt=%0d required 1 0 0",
                     bus.RAS_Restore, bus.RAS_Restore_TOS, bus.Ckpt_Count);
        end
        stall_cycles = (bus.Ctrl_Stall === 1'b1) ? 1 : 0;
        // A CALL offered during the repair must be ignored.
        step(1, 1, 0, 32'h2F0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.RAS_Restore !== 1'b0) begin
            errors++;
            $display("FAIL repair_pulse_width got %0d required 0", bus.RAS_Restore);
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.Ctrl_Stall === 1'b1) stall_cycles++;
            idle(1);
        end
        checks++;
        if (stall_cycles != 3) begin
            errors++;
            $display("FAIL repair_stall_cycles got %0d required 3", stall_cycles);
        end
        checks++;
        if (bus.Ckpt_Count !== 4'd0 || bus.Ctrl_Stall !== 1'b0) begin
            errors++;
            $display("FAIL repair_end got cnt=%0d stall=%0d required 0 0", bus.Ckpt_Count, bus.Ctrl_Stall);
        end
        idle(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL repair_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h300 + 32'(i * 4), 0, 0, 0, 0, 1);
        checks++;
        if (bus.Ckpt_Full !== 1'b1 || bus.Ckpt_Count !== 4'd8) begin
            errors++;
            $display("FAIL full_flag got full=%0d cnt=%0d required 1 8", bus.Ckpt_Full, bus.Ckpt_Count);
        end
        step(1, 1, 0, 32'h3F0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.Ckpt_Count !== 4'd8) begin
            errors++;
            $display("FAIL full_ignore got cnt=%0d required 8", bus.Ckpt_Count);
        end
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (bus.Ckpt_Count !== 4'd7 || bus.Ckpt_Full !== 1'b0) begin
            errors++;
            $display("FAIL full_resolve got cnt=%0d full=%0d required 7 0", bus.Ckpt_Count, bus.Ckpt_Full);
        end
        step(1, 1, 0, 32'h340, 1, 0, 0, 0, 1);
        checks++;
        if (bus.Ckpt_Count !== 4'd7) begin
            errors++;
            $display("FAIL enq_deq_same got cnt=%0d required 7", bus.Ckpt_Count);
        end
        // 9 CALLs accepted so far: Spec_TOS=9, and a flush must leave it there.
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (bus.Ckpt_Count !== 4'd0 || bus.RAS_Restore !== 1'b0 || bus.Ctrl_Stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got cnt=%0d restore=%0d stall=%0d required 0 0 0",
                     bus.Ckpt_Count, bus.RAS_Restore, bus.Ctrl_Stall);
        end
        step(1, 1, 0, 32'h350, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0, 0, 0);
        checks++;
        if (bus.RAS_Restore !== 1'b1 || bus.RAS_Restore_TOS !== 5'd9) begin
            errors++;
            $display("FAIL flush_keeps_tos got restore=%0d tos=%0d required 1 9", bus.RAS_Restore, bus.RAS_Restore_TOS);
        end
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_stall_drop();
        do_reset();
        step(1, 1, 0, 32'h400, 0, 0, 0, 1, 0);
        checks++;
        if (bus.Ckpt_Count !== 4'd0 || bus.RAS_Push !== 1'b0) begin
            errors++;
            $display("FAIL bpu_stall got cnt=%0d push=%0d required 0 0", bus.Ckpt_Count, bus.RAS_Push);
        end
        step(1, 1, 0, 32'h404, 0, 0, 0, 0, 1);
        step(1, 1, 0, 32'h408, 1, 1, 0, 0, 0);
        checks++;
        if (bus.RAS_Restore !== 1'b1 || bus.RAS_Restore_TOS !== 5'd0 || bus.Ckpt_Count !== 4'd0) begin
            errors++;
            $display("FAIL mispred_drop got restore=%0d tos=%0d cnt=%0d required 1 0 0",
                     bus.RAS_Restore, bus.RAS_Restore_TOS, bus.Ckpt_Count);
        end
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 33; i++) step(1, 1, 0, 32'h500 + 32'(i * 4), (i > 0), 0, 0, 0, 1);
        checks++;
        if (bus.Ckpt_Count !== 4'd1) begin
            errors++;
            $display("FAIL wrap_count got %0d required 1", bus.Ckpt_Count);
        end
        // The 33rd CALL was checkpointed at Spec_TOS=32 mod 32 = 0.
        step(0, 0, 0, 0, 1, 1, 0, 0, 0);
        checks++;
        if (bus.RAS_Restore !== 1'b1 || bus.RAS_Restore_TOS !== 5'd0) begin
            errors++;
            $display("FAIL wrap_tos got restore=%0d tos=%0d required 1 0", bus.RAS_Restore, bus.RAS_Restore_TOS);
        end
        idle(4);
        do_reset();
        step(1, 0, 1, 32'h0, 0, 0, 0, 0, !GUARD);
        checks++;
        if (bus.RAS_Pop !== !GUARD || bus.Ckpt_Count !== 4'd1) begin
            errors++;
            $display("FAIL underflow_ret got pop=%0d cnt=%0d required %0d 1", bus.RAS_Pop, bus.Ckpt_Count, !GUARD);
        end
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 32'h600, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0, 0, 0);
        checks++;
        if (bus.RAS_Restore !== 1'b1 || bus.RAS_Restore_TOS !== (GUARD ? 5'd0 : 5'd31)) begin
            errors++;
            $display("FAIL underflow_tos got restore=%0d tos=%0d required 1 %0d",
                     bus.RAS_Restore, bus.RAS_Restore_TOS, GUARD ? 0 : 31);
        end
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_repair();
        do_reset();
        step(1, 1, 0, 32'h700, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0, 0, 0);
        idle(1);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        checks++;
        if (bus.Ctrl_Stall !== 1'b0 || bus.RAS_Restore !== 1'b0 || bus.Ckpt_Count !== 4'd0 ||
            bus.RAS_Push !== 1'b0 || bus.RAS_Pop !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_settle got stall=%0d restore=%0d cnt=%0d push=%0d pop=%0d required all 0",
                     bus.Ctrl_Stall, bus.RAS_Restore, bus.Ckpt_Count, bus.RAS_Push, bus.RAS_Pop);
        end
        // Back in IDLE straight away: a new CALL is accepted.
        step(1, 1, 0, 32'h710, 0, 0, 0, 0, 1);
        checks++;
        if (bus.Ckpt_Count !== 4'd1) begin
            errors++;
            $display("FAIL rst_idle_accept got cnt=%0d required 1", bus.Ckpt_Count);
        end
        step(1, 1, 0, 32'h714, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1, 1, 0, 0);
        checks++;
        if (bus.RAS_Restore !== 1'b1 || bus.RAS_Restore_TOS !== 5'd0 ||
            bus.Ctrl_Stall !== 1'b1 || bus.Ckpt_Count !== 4'd0) begin
            errors++;
            $display("FAIL flush_mispred got restore=%0d tos=%0d stall=%0d cnt=%0d required 1 0 1 0",
                     bus.RAS_Restore, bus.RAS_Restore_TOS, bus.Ctrl_Stall, bus.Ckpt_Count);
        end
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    initial begin
        bus.Pred_Valid     = 1'b0;
        bus.Pred_Is_Call   = 1'b0;
        bus.Pred_Is_Ret    = 1'b0;
        bus.Pred_Next_PC   = '0;
        bus.Res_Valid      = 1'b0;
        bus.Res_Mispredict = 1'b0;
        bus.Flush          = 1'b0;
        bus.BPU__Stall     = 1'b0;
        test_reset();
        test_call();
        test_repair();
        test_full();
        test_stall_drop();
        test_wrap();
        test_reset_mid_repair();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
